// File: rtl/key_pkg.sv
// Shared widths, FSM state type and the 8-to-3 priority encode used by key_encoder83.
package key_pkg;

    localparam int unsigned KEY_W  = 8;
    localparam int unsigned CODE_W = 3;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESSED = 1'b1
    } key_state_e;

    // Highest-numbered low bit wins; code is 7 minus its index so it decodes back to the same LED.
    function automatic logic [CODE_W-1:0] prio_enc83(input logic [KEY_W-1:0] n);
        logic [CODE_W-1:0] r;
        r = '0;
        for (int i = 0; i < int'(KEY_W); i++) begin
            if (!n[i]) r = CODE_W'(int'(KEY_W) - 1 - i);
        end
        return r;
    endfunction

endpackage

// File: rtl/key_encoder83_if.sv
// Button input and encoded-key event bus between the encoder and downstream control logic.
interface key_encoder83_if;
    import key_pkg::*;

    logic [KEY_W-1:0]  keys_n;
    logic [CODE_W-1:0] code;
    logic              valid;
    logic              press;
    logic              released;

    modport master (input keys_n, output code, valid, press, released);
    modport slave  (output keys_n, input code, valid, press, released);
endinterface

// File: rtl/key_debounce.sv
// Two-flop synchroniser followed by a saturating stability counter; deb only follows a vector held long enough.
module key_debounce #(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 240000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] keys_n,
    output logic [WIDTH-1:0] deb
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] cand;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= '1;
            s2   <= '1;
            cand <= '1;
            cnt  <= '0;
            deb  <= '1;
        end else begin
            s1 <= keys_n;
            s2 <= s1;
            // Any movement restarts the window; the counter parks at its last value once committed.
            if (s2 != cand) begin
                cand <= s2;
                cnt  <= '0;
            end else if (cnt == CNT_LAST) begin
                deb <= cand;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/key_encoder83.sv
// Debounced 8-to-3 priority encoder for active-low push-buttons with held code, valid and press/release strobes.
module key_encoder83
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 240000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    key_encoder83_if.master         bus
);

    logic [KEY_W-1:0]  deb;
    logic [CODE_W-1:0] enc_c;
    logic              any_c;

    key_state_e        state;
    logic [CODE_W-1:0] code;
    logic              valid;
    logic              press;
    logic              released;

    key_debounce #(
        .WIDTH           (KEY_W),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .rst_n  (rst_n),
        .keys_n (bus.keys_n),
        .deb    (deb)
    );

    assign enc_c = prio_enc83(deb);
    assign any_c = (deb != '1);

    // Strobes default low every cycle so each lasts exactly one clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            code     <= '0;
            valid    <= 1'b0;
            press    <= 1'b0;
            released <= 1'b0;
        end else begin
            press    <= 1'b0;
            released <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_c) begin
                        state <= PRESSED;
                        code  <= enc_c;
                        valid <= 1'b1;
                        press <= 1'b1;
                    end
                end
                PRESSED: begin
                    if (!any_c) begin
                        state    <= IDLE;
                        valid    <= 1'b0;
                        released <= 1'b1;
                    end else if (enc_c != code) begin
                        code  <= enc_c;
                        press <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.code     = code;
    assign bus.valid    = valid;
    assign bus.press    = press;
    assign bus.released = released;

endmodule
